// File: rtl/blink_ctrl.sv
// blink_ctrl: blink/hold/timeout sequencing for the time-setting display.
// Selected field blinks; edits hold it solid; inactivity pulses timeout.
module blink_ctrl #(
  parameter int NUM_FIELDS    = 3,
  parameter int SEL_W         = 3,
  parameter int PHASE_TICKS   = 2,
  parameter int HOLD_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  edit,
  output logic [NUM_FIELDS-1:0] blank,
  output logic                  phase,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PW =
    (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam int HW =
    (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int IW =
    (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [PW-1:0] PLAST = PW'(PHASE_TICKS - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_TICKS - 1);
  localparam logic [IW-1:0] ILAST =
    IW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
  localparam logic [SEL_W-1:0] SMAX = SEL_W'(NUM_FIELDS);
  localparam logic TO_EN = (TIMEOUT_TICKS > 0);

  state_t          state, state_n;
  logic [SEL_W-1:0] sel_q;
  logic [PW-1:0]   pcnt, pcnt_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [IW-1:0]   icnt, icnt_n;
  logic            phase_n;
  logic [NUM_FIELDS-1:0] blank_d;
  logic            to_d;

  logic sel_ok;
  logic go_idle;
  logic go_blink;
  logic do_edit;
  logic do_tick;

  // Mutually exclusive events, highest priority first
  assign sel_ok   = (sel != '0) && (sel <= SMAX);
  assign go_idle  = !sel_ok;
  assign go_blink = sel_ok && ((sel != sel_q) || (state == IDLE));
  assign do_edit  = sel_ok && !go_blink && edit;
  assign do_tick  = sel_ok && !go_blink && !edit && tick;

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      pcnt    <= '0;
      hcnt    <= '0;
      icnt    <= '0;
      phase   <= 1'b0;
      blank   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel;
      pcnt    <= pcnt_n;
      hcnt    <= hcnt_n;
      icnt    <= icnt_n;
      phase   <= phase_n;
      blank   <= blank_d;
      timeout <= to_d;
    end
  end

  // Next state, blink phase and counters
  always_comb begin
    state_n = state;
    phase_n = phase;
    pcnt_n  = pcnt;
    hcnt_n  = hcnt;
    icnt_n  = icnt;
    unique case (1'b1)
      go_idle: begin
        state_n = IDLE;
        phase_n = 1'b0;
        pcnt_n  = '0;
        hcnt_n  = '0;
        icnt_n  = '0;
      end
      go_blink: begin
        state_n = BLINK;
        phase_n = 1'b0;
        pcnt_n  = '0;
        hcnt_n  = '0;
        icnt_n  = '0;
      end
      do_edit: begin
        state_n = HOLD;
        phase_n = 1'b0;
        pcnt_n  = '0;
        hcnt_n  = '0;
        icnt_n  = '0;
      end
      do_tick: begin
        if (TO_EN) begin
          if (icnt == ILAST) icnt_n = '0;
          else icnt_n = icnt + IW'(1);
        end
        if (state == BLINK) begin
          if (pcnt == PLAST) begin
            pcnt_n  = '0;
            phase_n = !phase;
          end else begin
            pcnt_n = pcnt + PW'(1);
          end
        end else if (state == HOLD) begin
          if (hcnt == HLAST) begin
            state_n = BLINK;
            hcnt_n  = '0;
            pcnt_n  = '0;
            phase_n = 1'b0;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Blank mask and timeout pulse for the next registered update
  always_comb begin
    blank_d = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      blank_d[i] = (state_n == BLINK) && phase_n &&
                   (sel == SEL_W'(i + 1));
    end
    to_d = do_tick && TO_EN && (icnt == ILAST);
  end

endmodule

// File: tb/tb_blink_ctrl.sv
// tb_blink_ctrl: scoreboard bench for blink_ctrl.
// Expected outputs queued at drive time, compared one clk later.
module tb_blink_ctrl;

  localparam int NF = 3;
  localparam int SW = 3;
  localparam int PT = 2;
  localparam int HT = 4;
  localparam int TT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [SW-1:0] sel;
  logic          edit;
  logic [NF-1:0] blank;
  logic          phase;
  logic          timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] exp_q[$];
  int         to_q[$];
  logic [2:0] bl_q[$];
  int         tick_n;

  int   m_st;
  int   m_pc;
  int   m_hc;
  int   m_ic;
  int   m_selq;
  bit   m_ph;
  bit   m_to;
  logic [2:0] m_bl;

  blink_ctrl #(
    .NUM_FIELDS   (NF),
    .SEL_W        (SW),
    .PHASE_TICKS  (PT),
    .HOLD_TICKS   (HT),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .sel    (sel),
    .edit   (edit),
    .blank  (blank),
    .phase  (phase),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_pc = 0; m_hc = 0; m_ic = 0;
    m_selq = 0; m_ph = 0; m_to = 0; m_bl = '0;
  endtask

  // Behavioural reference: 0 idle, 1 blink, 2 hold
  task automatic model(input bit t, input bit e, input int s);
    int nst;
    bit ok;
    nst = m_st;
    m_to = 0;
    ok = (s != 0) && (s <= NF);
    if (!ok) begin
      nst = 0; m_ph = 0; m_pc = 0; m_hc = 0; m_ic = 0;
    end else if (s != m_selq || m_st == 0) begin
      nst = 1; m_ph = 0; m_pc = 0; m_hc = 0; m_ic = 0;
    end else if (e) begin
      nst = 2; m_ph = 0; m_pc = 0; m_hc = 0; m_ic = 0;
    end else if (t) begin
      if (TT > 0) begin
        if (m_ic == TT - 1) begin
          m_to = 1;
          m_ic = 0;
        end else begin
          m_ic++;
        end
      end
      if (m_st == 1) begin
        if (m_pc == PT - 1) begin
          m_pc = 0;
          m_ph = !m_ph;
        end else begin
          m_pc++;
        end
      end else if (m_st == 2) begin
        if (m_hc == HT - 1) begin
          nst = 1; m_hc = 0; m_pc = 0; m_ph = 0;
        end else begin
          m_hc++;
        end
      end
    end
    m_selq = s;
    m_st = nst;
    m_bl = '0;
    if (nst == 1 && m_ph) m_bl[s-1] = 1'b1;
  endtask

  task automatic cyc(input logic t, input logic e,
                     input logic [SW-1:0] s);
    logic [4:0] x;
    tick = t; edit = e; sel = s;
    model(t, e, int'(s));
    exp_q.push_back({m_to, m_ph, m_bl});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("blank", 32'(blank), 32'(x[2:0]));
    chk("phase", 32'(phase), 32'(x[3]));
    chk("timeout", 32'(timeout), 32'(x[4]));
    if (t) begin
      tick_n++;
      bl_q.push_back(blank);
    end
    if (timeout) to_q.push_back(tick_n);
  endtask

  task automatic run(input int n, input logic [SW-1:0] s,
                     input int edit_at);
    for (int k = 1; k <= n; k++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(c == 3, (c == 3) && (k == edit_at), s);
      end
    end
  endtask

  task automatic clr();
    tick_n = 0;
    to_q.delete();
    bl_q.delete();
  endtask

  task automatic async_rst(input logic [SW-1:0] s, input string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_blank"}, 32'(blank), 32'd0);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    m_reset();
    exp_q.delete();
    tick = 0; edit = 0; sel = s;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 0; edit = 0; sel = '0;
    m_reset();
    clr();
    #12;
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // idle: no blinking, no timeout
    run(20, 3'd0, 0);
    chk("idle_to_cnt", to_q.size(), 0);

    // sel=2 blink pattern
    cyc(0, 0, 3'd2);
    clr();
    run(6, 3'd2, 0);
    for (int k = 1; k <= 6; k++) begin
      chk("blink_pat", 32'(bl_q[k-1]),
          ((k / 2) % 2 == 1) ? 32'h2 : 32'h0);
    end

    // sel=1, edit holds solid for HOLD_TICKS
    cyc(0, 0, 3'd1);
    run(2, 3'd1, 0);
    chk("sel1_on", 32'(blank), 32'h1);
    cyc(0, 1, 3'd1);
    chk("hold_blank", 32'(blank), 32'h0);
    clr();
    run(6, 3'd1, 0);
    chk("hold_t4", 32'(bl_q[3]), 32'h0);
    chk("hold_t5", 32'(bl_q[4]), 32'h0);
    chk("hold_t6", 32'(bl_q[5]), 32'h1);

    // second edit two ticks into hold
    cyc(0, 1, 3'd1);
    run(2, 3'd1, 0);
    cyc(0, 1, 3'd1);
    clr();
    run(6, 3'd1, 0);
    chk("rehold_t4", 32'(bl_q[3]), 32'h0);
    chk("rehold_t6", 32'(bl_q[5]), 32'h1);

    // edit and tick in one clk: tick not counted
    clr();
    run(7, 3'd1, 1);
    chk("edtk_t6", 32'(bl_q[5]), 32'h0);
    chk("edtk_t7", 32'(bl_q[6]), 32'h1);

    // sel change with edit: blink, not hold
    cyc(0, 1, 3'd2);
    clr();
    run(2, 3'd2, 0);
    chk("chg_edit", 32'(bl_q[1]), 32'h2);

    // out-of-range sel behaves as idle
    cyc(0, 0, 3'd5);
    clr();
    run(4, 3'd5, 0);
    chk("sel5_t2", 32'(bl_q[1]), 32'h0);
    chk("sel5_to", to_q.size(), 0);

    // timeout every 16 ticks
    cyc(0, 0, 3'd0);
    cyc(0, 0, 3'd3);
    clr();
    run(32, 3'd3, 0);
    chk("to_cnt", to_q.size(), 2);
    chk("to_first", to_q[0], 16);
    chk("to_second", to_q[1], 32);

    // edit at tick 10 pushes first timeout to 26
    cyc(0, 0, 3'd0);
    cyc(0, 0, 3'd3);
    clr();
    run(26, 3'd3, 10);
    chk("to_edit_cnt", to_q.size(), 1);
    chk("to_edit_at", to_q[0], 26);

    // async reset mid-blink
    cyc(0, 0, 3'd2);
    run(2, 3'd2, 0);
    chk("pre_rst_blank", 32'(blank), 32'h2);
    async_rst(3'd2, "rst_blink");
    cyc(0, 0, 3'd2);
    clr();
    run(16, 3'd2, 0);
    chk("rst_to_cnt", to_q.size(), 1);
    chk("rst_to_at", to_q[0], 16);

    // async reset mid-hold
    cyc(0, 1, 3'd2);
    run(1, 3'd2, 0);
    async_rst(3'd2, "rst_hold");
    cyc(0, 0, 3'd2);
    clr();
    run(2, 3'd2, 0);
    chk("rst_hold_blink", 32'(bl_q[1]), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_ctrl.md
Name: blink_ctrl

Overview:
- Parametrised blink controller for the watch's time-setting display.
- The mode FSM selects one of NUM_FIELDS digit fields for editing. The block drives a per-field blank mask so that only the selected field blinks.
- While the user is adjusting a value, the field is held solid. If no adjustment arrives within a set time, the block pulses a timeout so the mode FSM can return to normal display.
- Fully synchronous to the system clock. Timing is derived from a one-cycle tick enable.

Parameters:
- NUM_FIELDS, 3, number of display fields; minimum 1.
- SEL_W, 3, width of sel; must satisfy 2**SEL_W > NUM_FIELDS.
- PHASE_TICKS, 2, ticks per blink half-period; minimum 1.
- HOLD_TICKS, 4, ticks the field stays solid after an edit; minimum 1.
- TIMEOUT_TICKS, 16, ticks without activity before timeout; 0 disables timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick  in  1  one-cycle timebase enable pulse (e.g. 4 Hz).
- sel  in  SEL_W  0 = no edit; k in 1..NUM_FIELDS selects field k-1; values > NUM_FIELDS are treated as 0.
- edit  in  1  one-cycle pulse when the user adjusts the selected field.
- blank  out  NUM_FIELDS  registered; 1 = blank that field.
- phase  out  1  registered current blink phase; 1 = off half.
- timeout  out  1  registered one-cycle inactivity pulse.

Behaviour:
- Reset (async, rst=1):
  - blank=0, phase=0, timeout=0.
  - state=IDLE; phase_cnt, hold_cnt and idle_cnt all 0.
- Internal sel_q registers sel each cycle. A "sel change" means sel differs from sel_q.
- States: IDLE, BLINK, HOLD. Priority within a cycle, highest first: invalid sel, sel change, edit, tick.
- IDLE (sel invalid or 0):
  - blank=0, phase=0, all counters held at 0, no timeout.
  - A valid sel moves to BLINK with phase=0 and counters cleared.
- Any state, sel goes invalid/0 → IDLE next cycle. blank clears in that same registered update. Any pending timeout is suppressed.
- Any state, sel changes to a different valid field → BLINK with phase=0 and phase_cnt/idle_cnt cleared. An edit in that same cycle is ignored.
- BLINK:
  - blank[sel-1]=phase; all other bits 0.
  - On tick: phase_cnt+1. When phase_cnt==PHASE_TICKS-1, phase toggles and phase_cnt returns to 0.
  - edit → HOLD, with hold_cnt=0, phase=0, phase_cnt=0, idle_cnt=0.
- HOLD:
  - blank=0 and phase=0.
  - edit restarts hold_cnt=0 and clears idle_cnt.
  - On tick: hold_cnt+1. When hold_cnt==HOLD_TICKS-1, go to BLINK with phase=0 and phase_cnt=0.
- Edit and tick in the same cycle: edit wins and the tick is not counted by any counter.
- Timeout (TIMEOUT_TICKS>0):
  - idle_cnt counts ticks in BLINK and HOLD; it is cleared by edit or sel change.
  - On tick with idle_cnt==TIMEOUT_TICKS-1: timeout=1 for exactly one clk, idle_cnt returns to 0, and the state is unchanged. The block re-arms and repeats every TIMEOUT_TICKS ticks until sel goes to 0.
- Latency: all outputs are registered. The effect of tick, edit or sel appears on blank/phase/timeout one clk after the input cycle.
- Counter widths are $clog2(max value + 1) with a minimum of 1 bit. Counters never exceed max−1.
- A tick without the counter reaching its terminal value changes nothing but that counter.
- Reset asserted mid-blink or mid-hold immediately forces all outputs to their reset values. After release, with sel still valid, the block enters BLINK with phase 0.

Test Plan:
- Reset, then tick every 4 clk for 20 ticks with sel=0 and NUM_FIELDS=3 → blank=000, phase=0, timeout never asserted.
- sel=2, PHASE_TICKS=2, ticks every 4 clk:
  - → blank stays 000 for 2 ticks, then 010 for 2 ticks, then repeats.
  - Each blank change appears 1 clk after the terminal tick.
- sel=1 in BLINK with blank=001, then edit pulse, HOLD_TICKS=4:
  - → blank=000 one clk later, for exactly 4 ticks, then back to BLINK showing 000 for 2 ticks, then 001.
  - A second edit 2 ticks into HOLD → 4 more ticks solid.
- sel=3, TIMEOUT_TICKS=16, no edits → timeout 1-clk pulse 1 clk after the 16th tick, a second pulse after the 32nd. An edit at tick 10 → first pulse is instead at tick 26.
- Simultaneous events:
  - edit+tick in the same clk → the hold count excludes that tick.
  - sel 1→2 with edit in the same clk → BLINK on field 1 (blank=000, phase=0), no HOLD.
  - sel=5 with NUM_FIELDS=3 → treated as IDLE, blank=000.
- Assert rst mid-HOLD and mid-BLINK → outputs 0 asynchronously. Release with sel=2 → BLINK with phase 0, timeout count restarted.
